// File: rtl/dsdac_pkg.sv
// Shared types and default sizes for the delta-sigma DAC loop filter.
//   lf_state_e : gain-scheduling FSM states (encoding is visible on the state port)
//   INT_W      : integrator width; four bits of headroom above the tuning word
package dsdac_pkg;

  localparam int DIN_W_DEF     = 16;
  localparam int DOUT_BITS_DEF = 5;
  localparam int ERR_W_DEF     = 8;
  localparam int INT_W         = DIN_W_DEF + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_TRK  = 2'd2
  } lf_state_e;

endpackage

// File: rtl/dsdac_sat_add.sv
// Signed adder with a clamp to the unsigned tuning-word range [0, 2^OUT_W-1].
// Ports:
//   a_i, b_i : signed W-bit operands
//   sum_o    : clamped sum, still W bits wide and always non-negative
//   sat_o    : 1 when the clamp changed the result
module dsdac_sat_add #(
  parameter int W     = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                sat_o
);

  localparam logic signed [W:0] MAX_V = {{(W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic signed [W:0] sum_full;

  // One extra bit so the raw sum itself can never wrap.
  assign sum_full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    sum_o = sum_full[W-1:0];
    sat_o = 1'b0;
    if (sum_full < 0) begin
      sum_o = '0;
      sat_o = 1'b1;
    end else if (sum_full > MAX_V) begin
      sum_o = MAX_V[W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/dsdac_loop_filter.sv
// PI loop filter feeding the delta-sigma DAC modulator in the PLL tuning path.
// A gain-scheduling FSM uses high gain while acquiring, low gain while tracking.
//
//   state | meaning
//   IDLE  | open loop; din and out_set follow manual_set, err ignored
//   ACQ   | closed loop, acquisition gains, counting in-tolerance samples
//   TRK   | closed loop, tracking gains, locked=1, watching for large errors
//
// Ports:
//   clk_ref, rst          : reference clock, async active-high reset
//   VDD, VSS              : supply pins, no logic function
//   start, force_open     : close loop (pulse) / force open loop (level, wins)
//   manual_set            : open-loop code, seeds the integrator on loop close
//   err_valid, err        : signed error samples, one cycle per sample
//   din, mod_enable       : tuning word and enable to the modulator
//   out_set               : registered manual_set to the modulator
//   locked, sat, state    : status
module dsdac_loop_filter
  import dsdac_pkg::*;
#(
  parameter int DIN_W     = DIN_W_DEF,
  parameter int DOUT_BITS = DOUT_BITS_DEF,
  parameter int ERR_W     = ERR_W_DEF,
  parameter int KP_ACQ    = 2,
  parameter int KI_ACQ    = 6,
  parameter int KP_TRK    = 4,
  parameter int KI_TRK    = 9,
  parameter int LOCK_CNT  = 64,
  parameter int LOCK_TOL  = 2
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  input  logic                 VDD,
  input  logic                 VSS,
  input  logic                 start,
  input  logic                 force_open,
  input  logic [DOUT_BITS-1:0] manual_set,
  input  logic                 err_valid,
  input  logic [ERR_W-1:0]     err,
  output logic [DIN_W-1:0]     din,
  output logic                 mod_enable,
  output logic [DOUT_BITS-1:0] out_set,
  output logic                 locked,
  output logic                 sat,
  output logic [1:0]           state
);

  localparam int IW      = DIN_W + 4;
  localparam int LC_W    = $clog2(LOCK_CNT + 1);
  localparam int UNLOCK_N = 8;
  localparam int UC_W    = $clog2(UNLOCK_N + 1);

  localparam logic [ERR_W:0] TOL_V    = (ERR_W + 1)'(LOCK_TOL);
  localparam logic [ERR_W:0] UNTOL_V  = (ERR_W + 1)'(4 * LOCK_TOL);
  localparam logic [LC_W-1:0] LOCK_LAST   = LC_W'(LOCK_CNT - 1);
  localparam logic [UC_W-1:0] UNLOCK_LAST = UC_W'(UNLOCK_N - 1);

  lf_state_e               state_q;
  logic signed [IW-1:0]    integ_q;
  logic [DIN_W-1:0]        din_q;
  logic [DOUT_BITS-1:0]    out_set_q;
  logic                    mod_en_q;
  logic                    locked_q;
  logic                    sat_q;
  logic [LC_W-1:0]         lock_cnt_q;
  logic [UC_W-1:0]         unlock_cnt_q;

  logic signed [IW-1:0]    seed;
  logic signed [IW-1:0]    err_sx;
  logic signed [IW-1:0]    ex;
  logic signed [IW-1:0]    ki_term;
  logic signed [IW-1:0]    kp_term;
  logic signed [IW-1:0]    integ_d;
  logic signed [IW-1:0]    din_d;
  logic                    sat_integ;
  logic                    sat_din;
  logic [ERR_W:0]          err_s;
  logic [ERR_W:0]          err_abs;
  logic                    in_tol;
  logic                    big_err;

  logic                    unused_supply;
  logic [IW-DIN_W-1:0]     unused_din_hi;

  assign unused_supply = VDD ^ VSS;
  assign unused_din_hi = din_d[IW-1:DIN_W];

  // manual_set placed in the top bits of the tuning word (bumpless seed).
  assign seed = {{(IW - DIN_W){1'b0}}, manual_set, {(DIN_W - DOUT_BITS){1'b0}}};

  // Error aligned to the tuning-word MSB before the gain shifts.
  assign err_sx = {{(IW - ERR_W){err[ERR_W-1]}}, err};
  assign ex     = err_sx <<< (DIN_W - ERR_W);

  always_comb begin
    ki_term = ex >>> KI_ACQ;
    kp_term = ex >>> KP_ACQ;
    if (state_q == ST_TRK) begin
      ki_term = ex >>> KI_TRK;
      kp_term = ex >>> KP_TRK;
    end
  end

  dsdac_sat_add #(.W(IW), .OUT_W(DIN_W)) u_add_integ (
    .a_i   (integ_q),
    .b_i   (ki_term),
    .sum_o (integ_d),
    .sat_o (sat_integ)
  );

  // Proportional path rides on the already-updated integrator.
  dsdac_sat_add #(.W(IW), .OUT_W(DIN_W)) u_add_din (
    .a_i   (integ_d),
    .b_i   (kp_term),
    .sum_o (din_d),
    .sat_o (sat_din)
  );

  // One extra bit so |most negative code| is representable.
  assign err_s   = {err[ERR_W-1], err};
  assign err_abs = err_s[ERR_W] ? (~err_s + 1'b1) : err_s;
  assign in_tol  = (err_abs <= TOL_V);
  assign big_err = (err_abs > UNTOL_V);

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      integ_q      <= '0;
      din_q        <= '0;
      out_set_q    <= '0;
      mod_en_q     <= 1'b0;
      locked_q     <= 1'b0;
      sat_q        <= 1'b0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else if (force_open) begin
      // integ and sat are intentionally left alone until the next start.
      state_q      <= ST_IDLE;
      din_q        <= seed[DIN_W-1:0];
      out_set_q    <= manual_set;
      mod_en_q     <= 1'b0;
      locked_q     <= 1'b0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else begin
      if (state_q != ST_IDLE && err_valid) begin
        integ_q <= integ_d;
        din_q   <= din_d[DIN_W-1:0];
        sat_q   <= sat_integ | sat_din;
      end
      case (state_q)
        ST_IDLE: begin
          out_set_q <= manual_set;
          din_q     <= seed[DIN_W-1:0];
          if (start) begin
            state_q      <= ST_ACQ;
            integ_q      <= seed;
            mod_en_q     <= 1'b1;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
          end
        end
        ST_ACQ: begin
          if (err_valid) begin
            if (!in_tol) begin
              lock_cnt_q <= '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
              state_q      <= ST_TRK;
              locked_q     <= 1'b1;
              lock_cnt_q   <= '0;
              unlock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + LC_W'(1);
            end
          end
        end
        ST_TRK: begin
          if (err_valid) begin
            if (!big_err) begin
              unlock_cnt_q <= '0;
            end else if (unlock_cnt_q == UNLOCK_LAST) begin
              state_q      <= ST_ACQ;
              locked_q     <= 1'b0;
              lock_cnt_q   <= '0;
              unlock_cnt_q <= '0;
            end else begin
              unlock_cnt_q <= unlock_cnt_q + UC_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mod_en_q <= 1'b0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign din        = din_q;
  assign mod_enable = mod_en_q;
  assign out_set    = out_set_q;
  assign locked     = locked_q;
  assign sat        = sat_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dsdac_loop_filter.sv
// Scoreboard bench for dsdac_loop_filter: stimulus pushes hand-computed
// expectations, a monitor pops one per presented output cycle and compares.
module tb_dsdac_loop_filter;

  localparam int IDLE = 0;
  localparam int ACQ  = 1;
  localparam int TRK  = 2;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        VDD, VSS;
  logic        start, force_open;
  logic [4:0]  manual_set;
  logic        err_valid;
  logic [7:0]  err;
  logic [15:0] din;
  logic        mod_enable;
  logic [4:0]  out_set;
  logic        locked;
  logic        sat;
  logic [1:0]  state;
  logic        chk_req;

  typedef struct {
    logic [15:0] din;
    logic        sat;
    logic [1:0]  st;
    logic        locked;
    logic        mod_en;
    logic [4:0]  out_set;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  dsdac_loop_filter dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .VDD        (VDD),
    .VSS        (VSS),
    .start      (start),
    .force_open (force_open),
    .manual_set (manual_set),
    .err_valid  (err_valid),
    .err        (err),
    .din        (din),
    .mod_enable (mod_enable),
    .out_set    (out_set),
    .locked     (locked),
    .sat        (sat),
    .state      (state)
  );

  always #5 clk_ref = ~clk_ref;

  function automatic exp_t mk(input int d, input int s, input int st, input int lk,
                              input int me, input int os, input string nm);
    exp_t e;
    e.din     = 16'(d);
    e.sat     = 1'(s);
    e.st      = 2'(st);
    e.locked  = 1'(lk);
    e.mod_en  = 1'(me);
    e.out_set = 5'(os);
    e.name    = nm;
    return e;
  endfunction

  task automatic cmp(input exp_t e);
    n_checks++;
    if (din === e.din && sat === e.sat && state === e.st && locked === e.locked &&
        mod_enable === e.mod_en && out_set === e.out_set) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got din=%h sat=%b state=%0d locked=%b mod_en=%b out_set=%0d, expected din=%h sat=%b state=%0d locked=%b mod_en=%b out_set=%0d",
               e.name, din, sat, state, locked, mod_enable, out_set,
               e.din, e.sat, e.st, e.locked, e.mod_en, e.out_set);
    end
  endtask

  // Monitor: every cycle that carried a sample or check request presents an output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_ref);
      if (err_valid || chk_req) begin
        @(negedge clk_ref);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
        end else begin
          e = q.pop_front();
          cmp(e);
        end
      end
    end
  end

  task automatic step(input bit v, input int e, input bit chk, input exp_t x);
    err_valid = v;
    err       = 8'(e);
    chk_req   = chk;
    if (v || chk) q.push_back(x);
    @(posedge clk_ref);
    #1;
    err_valid = 1'b0;
    chk_req   = 1'b0;
  endtask

  task automatic idle_tick();
    exp_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, "none");
    step(1'b0, 0, 1'b0, dummy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; VDD = 1'b1; VSS = 1'b0;
    start = 1'b0; force_open = 1'b0; manual_set = 5'd12;
    err_valid = 1'b0; err = '0; chk_req = 1'b0;
    #2;

    // 1: reset and open-loop behaviour
    step(0, 0, 1, mk(0, 0, IDLE, 0, 0, 0, "reset_state"));
    rst = 1'b0;
    step(0, 0, 1, mk(16'h6000, 0, IDLE, 0, 0, 12, "idle_din"));
    step(1, 100, 0, mk(16'h6000, 0, IDLE, 0, 0, 12, "idle_err_ignored"));

    // 2: loop close and first sample
    start = 1'b1;
    step(0, 0, 1, mk(16'h6000, 0, ACQ, 0, 1, 12, "start_acq"));
    start = 1'b0;
    step(1, 16, 0, mk(16'h6440, 0, ACQ, 0, 1, 12, "acq_first_sample"));

    // 3: 63 in-tol then an out-of-tol sample clears the lock count
    for (int i = 0; i < 63; i++)
      step(1, 0, 0, mk(16'h6040, 0, ACQ, 0, 1, 12, "acq_zero"));
    step(1, 3, 0, mk(16'h610C, 0, ACQ, 0, 1, 12, "tol_break"));
    step(1, -2, 0, mk(16'h5FC4, 0, ACQ, 0, 1, 12, "in_tol_neg2"));
    for (int i = 0; i < 62; i++)
      step(1, 0, 0, mk(16'h6044, 0, ACQ, 0, 1, 12, "acq_count"));
    // 64th in-tol sample locks, still with acquisition gains
    step(1, 2, 0, mk(16'h60CC, 0, TRK, 1, 1, 12, "lock_acq_gain"));

    // 4: seven large errors then a boundary sample keeps lock
    for (int k = 1; k <= 7; k++)
      step(1, 9, 0, mk(16'h604C + 4 * k + 16'h90, 0, TRK, 1, 1, 12, "trk_partial"));
    step(1, 8, 0, mk(16'h60EC, 0, TRK, 1, 1, 12, "trk_boundary8"));
    for (int k = 1; k <= 8; k++)
      step(1, 9, 0, mk(16'h606C + 4 * k + 16'h90, 0, (k == 8) ? ACQ : TRK,
                       (k == 8) ? 0 : 1, 1, 12, "trk_unlock"));

    force_open = 1'b1;
    step(0, 0, 1, mk(16'h6000, 0, IDLE, 0, 0, 12, "force_open"));
    force_open = 1'b0;

    // 5: saturation at full scale, then full-scale negative error
    manual_set = 5'd31;
    step(0, 0, 1, mk(16'hF800, 0, IDLE, 0, 0, 31, "idle_ms31"));
    start = 1'b1;
    step(0, 0, 1, mk(16'hF800, 0, ACQ, 0, 1, 31, "start_ms31"));
    start = 1'b0;
    for (int k = 0; k < 4; k++)
      step(1, 127, 0, mk(16'hFFFF, 1, ACQ, 0, 1, 31, "din_clamp_hi"));
    step(1, 127, 0, mk(16'hFFFF, 1, ACQ, 0, 1, 31, "integ_clamp_hi"));
    step(1, -128, 0, mk(16'hDDFF, 0, ACQ, 0, 1, 31, "neg_full_scale"));

    // 6: force_open priority, bumpless restart, async reset
    force_open = 1'b1;
    step(0, 0, 1, mk(16'hF800, 0, IDLE, 0, 0, 31, "force_from_acq"));
    start = 1'b1;
    step(0, 0, 1, mk(16'hF800, 0, IDLE, 0, 0, 31, "start_and_force"));
    start = 1'b0; force_open = 1'b0;
    step(0, 0, 1, mk(16'hF800, 0, IDLE, 0, 0, 31, "stays_idle"));
    start = 1'b1;
    step(0, 0, 1, mk(16'hF800, 0, ACQ, 0, 1, 31, "restart"));
    start = 1'b0;
    step(1, 16, 0, mk(16'hFC40, 0, ACQ, 0, 1, 31, "reseed_bumpless"));
    idle_tick();
    #2;
    rst = 1'b1;
    #1;
    cmp(mk(0, 0, IDLE, 0, 0, 0, "async_rst"));
    @(posedge clk_ref);
    #1;
    step(0, 0, 1, mk(0, 0, IDLE, 0, 0, 0, "rst_hold"));
    rst = 1'b0;
    step(0, 0, 1, mk(16'hF800, 0, IDLE, 0, 0, 31, "post_rst_idle"));

    idle_tick();
    idle_tick();
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_leftover: got %0d entries, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
